instr_decoder_b: RTL and testbench

INSTR_DECODER_B -- requirements
Module: instr_decoder_b

---
 rtl/instr_decoder_b.sv | 96 +++++++++
 tb/tb_instr_decoder_b.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_decoder_b.sv
// RV32I B-type branch decoder, one registered stage with stall/flush control.
// Optional backward-taken hint enabled by defining INSTR_DECODER_B_BTFN_HINT_EN.
module instr_decoder_b #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            instr_valid,
  input  logic [XLEN-1:0] instruction,
  input  logic            stall,
  input  logic            flush,
  output logic            out_valid,
  output logic            illegal,
  output logic [3:0]      alu_op,
  output logic [2:0]      cmp_op,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [XLEN-1:0] immediate,
  output logic            pred_taken
);

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [3:0] ALU_SUB   = 4'b0001;

  typedef struct packed {
    logic            illegal;
    logic [3:0]      alu_op;
    logic [2:0]      cmp_op;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] imm;
  } dec_t;

  dec_t dec_d, dec_q;
  logic out_valid_q;
  logic legal;
  logic [2:0] funct3;

  assign funct3 = instruction[14:12];
  // funct3 010/011 are the only reserved encodings in the branch major opcode
  assign legal  = (instruction[6:0] == OP_BRANCH) && (funct3[2:1] != 2'b01);

  always_comb begin
    dec_d = '0;
    dec_d.illegal = 1'b1;
    if (legal) begin
      dec_d.illegal = 1'b0;
      dec_d.alu_op  = ALU_SUB;
      dec_d.cmp_op  = funct3;
      dec_d.rs1     = instruction[19:15];
      dec_d.rs2     = instruction[24:20];
      dec_d.imm     = {{(XLEN-12){instruction[31]}}, instruction[7],
                       instruction[30:25], instruction[11:8], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      dec_q       <= '0;
    end else if (flush) begin
      out_valid_q   <= 1'b0;
      dec_q.illegal <= 1'b0;
    end else if (!stall) begin
      out_valid_q <= instr_valid;
      dec_q       <= dec_d;
    end
  end

`ifdef INSTR_DECODER_B_BTFN_HINT_EN
  logic pred_q;

  // backward branch (negative offset) predicted taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      pred_q <= 1'b0;
    else if (flush)
      pred_q <= 1'b0;
    else if (!stall)
      pred_q <= legal & instr_valid & dec_d.imm[XLEN-1];
  end

  assign pred_taken = pred_q;
`else
  assign pred_taken = 1'b0;
`endif

  assign out_valid = out_valid_q;
  assign illegal   = dec_q.illegal;
  assign alu_op    = dec_q.alu_op;
  assign cmp_op    = dec_q.cmp_op;
  assign rs1       = dec_q.rs1;
  assign rs2       = dec_q.rs2;
  assign immediate = dec_q.imm;

endmodule

// File: tb/tb_instr_decoder_b.sv
// Self-checking bench for instr_decoder_b: directed spec vectors plus
// randomized traffic checked against a behavioural decode model.
module tb_instr_decoder_b;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic [31:0] instruction;
  logic        stall;
  logic        flush;
  logic        out_valid;
  logic        illegal;
  logic [3:0]  alu_op;
  logic [2:0]  cmp_op;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [31:0] immediate;
  logic        pred_taken;

  int total = 0;
  int bad   = 0;

  instr_decoder_b #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid),
    .instruction(instruction), .stall(stall), .flush(flush),
    .out_valid(out_valid), .illegal(illegal), .alu_op(alu_op),
    .cmp_op(cmp_op), .rs1(rs1), .rs2(rs2), .immediate(immediate),
    .pred_taken(pred_taken)
  );

  always #5 clk = ~clk;

`ifdef INSTR_DECODER_B_BTFN_HINT_EN
  localparam bit HINT = 1'b1;
`else
  localparam bit HINT = 1'b0;
`endif

  // layout: {out_valid, illegal, alu_op, cmp_op, rs1, rs2, immediate, pred_taken}
  function automatic logic [51:0] observed();
    return {out_valid, illegal, alu_op, cmp_op, rs1, rs2, immediate, pred_taken};
  endfunction

  // Decode of a valid word, same layout minus out_valid, from the ISA rules.
  function automatic logic [50:0] ref_dec(input logic [31:0] w);
    int f3, off;
    bit legal;
    logic [31:0] imm;
    f3    = int'(w[14:12]);
    legal = (w[6:0] == 7'h63) && (f3 inside {0, 1, 4, 5, 6, 7});
    off   = int'(w[31]) * 4096 + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
    if (off >= 4096) off = off - 8192;
    imm = off;
    if (legal)
      return {1'b0, 4'd1, w[14:12], w[19:15], w[24:20], imm, HINT && (off < 0)};
    return {1'b1, 50'd0};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] w, input logic s, input logic f);
    instr_valid = v; instruction = w; stall = s; flush = f;
  endtask

  task automatic test_reset();
    logic [51:0] o;
    rst_n = 1'b0;
    drive(1'b1, 32'h02106063, 1'b0, 1'b0);
    #2;
    o = observed();
    total++;
    if (o !== 52'd0) begin bad++; $display("FAIL reset_state got=%h exp=%h", o, 52'd0); end
    step();
    o = observed();
    total++;
    if (o !== 52'd0) begin bad++; $display("FAIL reset_hold_edge got=%h exp=%h", o, 52'd0); end
    rst_n = 1'b1;
    step();
    o = observed();
    total++;
    if (o !== {1'b1, 1'b0, 4'd1, 3'b110, 5'd0, 5'd1, 32'd32, 1'b0}) begin
      bad++; $display("FAIL first_capture got=%h", o);
    end
  endtask

  task automatic test_bltu();
    logic [51:0] o;
    drive(1'b1, 32'h02106063, 1'b0, 1'b0);
    step();
    o = observed();
    total++;
    if (o !== {1'b1, 1'b0, 4'd1, 3'b110, 5'd0, 5'd1, 32'd32, 1'b0}) begin
      bad++; $display("FAIL bltu got=%h", o);
    end
  endtask

  task automatic test_funct3_sweep();
    logic [31:0] words [5] = '{32'h02100063, 32'h02101063, 32'h02104063, 32'h02105063, 32'h02107063};
    logic [2:0]  f3s   [5] = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b111};
    logic [51:0] o, e;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, words[i], 1'b0, 1'b0);
      step();
      o = observed();
      e = {1'b1, 1'b0, 4'd1, f3s[i], 5'd0, 5'd1, 32'd32, 1'b0};
      total++;
      if (o !== e) begin bad++; $display("FAIL sweep_%0d got=%h exp=%h", i, o, e); end
    end
  endtask

  task automatic test_illegal();
    logic [31:0] words [3] = '{32'hFFFFFFFF, 32'h02102063, 32'h02103033};
    logic [51:0] o, e;
    e = {1'b1, 1'b1, 50'd0};
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, words[i], 1'b0, 1'b0);
      step();
      o = observed();
      total++;
      if (o !== e) begin bad++; $display("FAIL illegal_%0d got=%h exp=%h", i, o, e); end
    end
  endtask

  task automatic test_backward();
    logic [51:0] o, e;
    drive(1'b1, 32'hFE000EE3, 1'b0, 1'b0);
    step();
    o = observed();
    e = {1'b1, 1'b0, 4'd1, 3'b000, 5'd0, 5'd0, 32'hFFFFFFFC, HINT};
    total++;
    if (o !== e) begin bad++; $display("FAIL backward got=%h exp=%h", o, e); end
    // instr_valid low: valid and hint must drop
    drive(1'b0, 32'hFE000EE3, 1'b0, 1'b0);
    step();
    total++;
    if ({out_valid, pred_taken} !== 2'b00) begin
      bad++; $display("FAIL invalid_drop got=%b exp=00", {out_valid, pred_taken});
    end
  endtask

  task automatic test_stall_flush();
    logic [51:0] o, e;
    logic [31:0] r;
    drive(1'b1, 32'hFE000EE3, 1'b0, 1'b0);
    step();
    e = {1'b1, 1'b0, 4'd1, 3'b000, 5'd0, 5'd0, 32'hFFFFFFFC, HINT};
    for (int i = 0; i < 3; i++) begin
      r = $urandom();
      drive(1'b1, {r[31:7], 7'h63}, 1'b1, 1'b0);
      step();
      o = observed();
      total++;
      if (o !== e) begin bad++; $display("FAIL stall_hold_%0d got=%h exp=%h", i, o, e); end
    end
    drive(1'b1, 32'h02106063, 1'b1, 1'b1);
    step();
    total++;
    if ({out_valid, illegal, pred_taken} !== 3'b000) begin
      bad++; $display("FAIL stall_flush got=%b exp=000", {out_valid, illegal, pred_taken});
    end
    // flush clears a captured illegal flag and drops the incoming word
    drive(1'b1, 32'hFFFFFFFF, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'hFE000EE3, 1'b0, 1'b1);
    step();
    total++;
    if ({out_valid, illegal, pred_taken} !== 3'b000) begin
      bad++; $display("FAIL flush_only got=%b exp=000", {out_valid, illegal, pred_taken});
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r, w;
    logic        v, s, f;
    logic        ev, ep;
    logic [50:0] ed;
    bit          k_all, k_ill;
    logic [51:0] o;
    // bench starts this task right after a flush cycle
    ev = 1'b0; ep = 1'b0; ed = '0; k_all = 1'b0; k_ill = 1'b1;
    for (int i = 0; i < 400; i++) begin
      r = $urandom();
      w = ($urandom_range(0, 3) != 0) ? {r[31:7], 7'h63} : r;
      v = ($urandom_range(0, 4) != 0);
      s = ($urandom_range(0, 4) == 0);
      f = ($urandom_range(0, 7) == 0);
      drive(v, w, s, f);
      step();
      if (f) begin
        ev = 1'b0; ep = 1'b0; ed[50] = 1'b0; k_all = 1'b0; k_ill = 1'b1;
      end else if (!s) begin
        ev = v;
        if (v) begin ed = ref_dec(w); ep = ed[0]; k_all = 1'b1; k_ill = 1'b1; end
        else   begin ep = 1'b0; k_all = 1'b0; k_ill = 1'b0; end
      end
      o = observed();
      total++;
      if ({out_valid, pred_taken} !== {ev, ep}) begin
        bad++; $display("FAIL rand_valid_%0d got=%b exp=%b", i, {out_valid, pred_taken}, {ev, ep});
      end
      if (k_all) begin
        total++;
        if (o[50:0] !== ed) begin bad++; $display("FAIL rand_dec_%0d w=%h got=%h exp=%h", i, w, o[50:0], ed); end
      end else if (k_ill) begin
        total++;
        if (illegal !== ed[50]) begin bad++; $display("FAIL rand_ill_%0d got=%b exp=%b", i, illegal, ed[50]); end
      end
    end
  endtask

  task automatic test_async_reset();
    logic [51:0] o;
    drive(1'b1, 32'hFE000EE3, 1'b0, 1'b0);
    step();
    total++;
    if (out_valid !== 1'b1) begin bad++; $display("FAIL async_pre got=%b exp=1", out_valid); end
    drive(1'b1, 32'h02106063, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    o = observed();
    total++;
    if (o !== 52'd0) begin bad++; $display("FAIL async_reset got=%h exp=%h", o, 52'd0); end
    step();
    #3;
    rst_n = 1'b1;
    drive(1'b1, 32'h02105063, 1'b0, 1'b0);
    step();
    o = observed();
    total++;
    if (o !== {1'b1, 1'b0, 4'd1, 3'b101, 5'd0, 5'd1, 32'd32, 1'b0}) begin
      bad++; $display("FAIL post_reset_capture got=%h", o);
    end
  endtask

  initial begin
    test_reset();
    test_bltu();
    test_funct3_sweep();
    test_illegal();
    test_backward();
    test_stall_flush();
    test_back_to_back();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
